// File: rtl/fibo_job_dispatcher.sv
// fibo_job_dispatcher: queues term-count requests and feeds them one at a
// time to a Fibonacci controller FSM via a Start/Done level handshake.
// The dispatcher forces a Start-low gap between jobs, aborts a job through a
// watchdog, and keeps a saturating count of jobs that ended with Done.
module fibo_job_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int N_W     = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req_Valid,
  input  logic [N_W-1:0]   Req_N,
  output logic             Req_Ready,
  output logic             Start,
  output logic [N_W-1:0]   N_Out,
  input  logic             Done,
  output logic             Busy,
  output logic [CNT_W-1:0] Job_Count,
  output logic             Timeout_Err,
  input  logic             Err_Clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t           state, state_nxt;

  logic [N_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;
  logic             full, empty, push, pop;

  logic [TMR_W-1:0] timer, timer_nxt;
  logic             start_nxt, err_nxt;
  logic [N_W-1:0]   nout_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign full      = (occ == OCC_FULL);
  assign empty     = (occ == '0);
  // Full blocks a push even when a pop happens in the same cycle.
  assign Req_Ready = !full && !Rst;
  assign push      = Req_Valid && Req_Ready;
  // Pop looks at the registered occupancy, so a fresh push waits one cycle.
  assign pop       = (state == IDLE) && !empty;
  assign Busy      = (state != IDLE) || !empty;

  // FIFO pointers and occupancy (control, reset).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage (data, not reset).
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= Req_N;
  end

  // Job sequencing: next state and next registered outputs.
  always_comb begin
    state_nxt = state;
    start_nxt = Start;
    nout_nxt  = N_Out;
    timer_nxt = timer;
    cnt_nxt   = Job_Count;
    err_nxt   = Timeout_Err;
    if (Err_Clr) err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          nout_nxt  = mem[rd_ptr];
          start_nxt = 1'b1;
          timer_nxt = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        timer_nxt = timer + TMR_ONE;
        // Done takes priority over a watchdog expiry in the same cycle.
        if (Done) begin
          start_nxt = 1'b0;
          cnt_nxt   = sat_inc(Job_Count);
          state_nxt = COOL;
        end else if (timer == TMR_LAST) begin
          start_nxt = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = COOL;
        end
      end
      COOL: begin
        start_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        start_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      Start       <= 1'b0;
      N_Out       <= '0;
      timer       <= '0;
      Job_Count   <= '0;
      Timeout_Err <= 1'b0;
    end else begin
      state       <= state_nxt;
      Start       <= start_nxt;
      N_Out       <= nout_nxt;
      timer       <= timer_nxt;
      Job_Count   <= cnt_nxt;
      Timeout_Err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fibo_job_dispatcher.sv
// Bench for fibo_job_dispatcher: two instances share every input, one with a
// 16-bit job counter and one with a 2-bit counter to exercise saturation.
module tb_fibo_job_dispatcher;

  localparam int DEPTH   = 4;
  localparam int N_W     = 8;
  localparam int TIMEOUT = 64;

  logic           clk, rst, req_valid, done, err_clr;
  logic [N_W-1:0] req_n;
  logic           ready, start, busy, err;
  logic [N_W-1:0] nout;
  logic [15:0]    cnt;
  logic           ready2, start2, busy2, err2;
  logic [N_W-1:0] nout2;
  logic [1:0]     cnt2;

  fibo_job_dispatcher #(.DEPTH(DEPTH), .N_W(N_W), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .Clk(clk), .Rst(rst), .Req_Valid(req_valid), .Req_N(req_n), .Req_Ready(ready),
    .Start(start), .N_Out(nout), .Done(done), .Busy(busy), .Job_Count(cnt),
    .Timeout_Err(err), .Err_Clr(err_clr));

  fibo_job_dispatcher #(.DEPTH(DEPTH), .N_W(N_W), .TIMEOUT(TIMEOUT), .CNT_W(2)) dut_sat (
    .Clk(clk), .Rst(rst), .Req_Valid(req_valid), .Req_N(req_n), .Req_Ready(ready2),
    .Start(start2), .N_Out(nout2), .Done(done), .Busy(busy2), .Job_Count(cnt2),
    .Timeout_Err(err2), .Err_Clr(err_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of pending jobs plus a description of the job
  // in flight (running, age in cycles, cooling) and a plain job tally.
  int q[$];
  bit m_start, m_cool, m_err;
  int m_nout, m_age, m_jobs;
  bit last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock: check ready before the edge, advance model, check after.
  task automatic step();
    bit push, set_err, rdy_exp;
    #1;
    rdy_exp  = (q.size() < DEPTH) && !rst;
    last_rdy = ready;
    chk("ready", 32'(ready), 32'(rdy_exp));
    chk("ready_sat", 32'(ready2), 32'(rdy_exp));
    push = req_valid && rdy_exp;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_start = 0; m_cool = 0; m_err = 0; m_nout = 0; m_age = 0; m_jobs = 0;
    end else begin
      set_err = 0;
      if (m_start) begin
        if (done) begin
          m_start = 0; m_jobs++; m_cool = 1;
        end else if (m_age == TIMEOUT - 1) begin
          m_start = 0; set_err = 1; m_cool = 1;
        end else begin
          m_age++;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (q.size() != 0) begin
        m_nout = q.pop_front(); m_start = 1; m_age = 0;
      end
      if (err_clr) m_err = 0;
      if (set_err) m_err = 1;
      if (push) q.push_back(int'(req_n));
    end
    #1;
    chk("start", 32'(start), 32'(m_start));
    chk("n_out", 32'(nout), 32'(m_nout));
    chk("busy", 32'(busy), 32'(m_start || m_cool || q.size() != 0));
    chk("job_count", 32'(cnt), 32'(min_i(m_jobs, 65535)));
    chk("timeout_err", 32'(err), 32'(m_err));
    chk("start_sat", 32'(start2), 32'(m_start));
    chk("n_out_sat", 32'(nout2), 32'(m_nout));
    chk("busy_sat", 32'(busy2), 32'(m_start || m_cool || q.size() != 0));
    chk("job_count_sat", 32'(cnt2), 32'(min_i(m_jobs, 3)));
    chk("timeout_err_sat", 32'(err2), 32'(m_err));
  endtask

  task automatic set_in(input bit r, input bit v, input int n, input bit d, input bit c);
    rst = r; req_valid = v; req_n = N_W'(n); done = d; err_clr = c;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!start && k < 10) begin step(); k++; end
    chk("start_seen", 32'(start), 32'd1);
  endtask

  task automatic push_one(input int n);
    set_in(0, 1, n, 0, 0); step();
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic finish_job();
    done = 1; step(); done = 0;
  endtask

  typedef struct {
    bit             rst, vld;
    logic [N_W-1:0] n;
    bit             done, rdy, start;
    logic [N_W-1:0] nout;
    bit             busy;
    int             cnt;
  } vec_t;

  vec_t tv[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d", total);
    $fatal(1);
  end

  initial begin
    int base, hi, seen;
    set_in(1, 0, 0, 0, 0);
    m_start = 0; m_cool = 0; m_err = 0; m_nout = 0; m_age = 0; m_jobs = 0;

    // Basic job: reset, push N=5, Done on the fourth Start-high cycle.
    tv[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1] = '{0, 1, 5, 0, 1, 0, 0, 1, 0};
    tv[2] = '{0, 0, 0, 0, 1, 1, 5, 1, 0};
    tv[3] = '{0, 0, 0, 0, 1, 1, 5, 1, 0};
    tv[4] = '{0, 0, 0, 0, 1, 1, 5, 1, 0};
    tv[5] = '{0, 0, 0, 0, 1, 1, 5, 1, 0};
    tv[6] = '{0, 0, 0, 1, 1, 0, 5, 1, 1};
    tv[7] = '{0, 0, 0, 0, 1, 0, 5, 0, 1};
    for (int i = 0; i < 8; i++) begin
      set_in(tv[i].rst, tv[i].vld, int'(tv[i].n), tv[i].done, 0);
      step();
      chk($sformatf("tv%0d_rdy", i), 32'(last_rdy), 32'(tv[i].rdy));
      chk($sformatf("tv%0d_start", i), 32'(start), 32'(tv[i].start));
      chk($sformatf("tv%0d_nout", i), 32'(nout), 32'(tv[i].nout));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("tv%0d_cnt", i), 32'(cnt), 32'(tv[i].cnt));
      chk($sformatf("tv%0d_err", i), 32'(err), 32'd0);
    end

    // Back-to-back pushes until the FIFO fills behind a running job.
    seen = 1;
    for (int k = 0; k < 20 && seen <= 5; k++) begin
      set_in(0, 1, seen, 0, 0);
      step();
      if (last_rdy) seen++;
    end
    chk("fill_all_accepted", 32'(seen), 32'd6);
    set_in(0, 1, 6, 0, 0);
    step();
    chk("full_not_ready", 32'(last_rdy), 32'd0);
    set_in(0, 0, 0, 0, 0);
    for (int j = 1; j <= 5; j++) begin
      wait_start();
      chk("job_order", 32'(nout), 32'(j));
      finish_job();
    end
    step(); step();
    chk("five_jobs_count", 32'(cnt), 32'd6);
    chk("idle_after_jobs", 32'(busy), 32'd0);

    // Watchdog: no Done, Start stays high for exactly TIMEOUT cycles.
    base = int'(cnt);
    push_one(7);
    wait_start();
    hi = 0;
    while (start && hi < 100) begin hi++; step(); end
    chk("timeout_len", 32'(hi), 32'(TIMEOUT));
    chk("timeout_err_set", 32'(err), 32'd1);
    chk("timeout_no_count", 32'(cnt), 32'(base));
    err_clr = 1; step(); err_clr = 0;
    chk("err_cleared", 32'(err), 32'd0);

    // Done outside RUN is ignored; Done on the expiry cycle counts.
    base = int'(cnt);
    done = 1; step(); step(); done = 0;
    chk("done_idle_ignored", 32'(cnt), 32'(base));
    push_one(3);
    wait_start();
    done = 1; step(); step(); step(); done = 0;
    chk("done_cool_ignored", 32'(cnt), 32'(base + 1));
    step(); step();
    push_one(9);
    wait_start();
    for (int k = 0; k < TIMEOUT - 1; k++) step();
    chk("still_running", 32'(start), 32'd1);
    finish_job();
    chk("edge_done_stops", 32'(start), 32'd0);
    chk("edge_done_counts", 32'(cnt), 32'(base + 2));
    chk("edge_done_no_err", 32'(err), 32'd0);
    step(); step();

    // Reset in the middle of a job with two more queued.
    push_one(11);
    wait_start();
    push_one(12);
    push_one(13);
    set_in(1, 0, 0, 0, 0); step();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    set_in(0, 0, 0, 0, 0);
    push_one(14);
    wait_start();
    chk("post_rst_nout", 32'(nout), 32'd14);
    finish_job();
    step(); step();

    // Saturation on the narrow counter: five jobs in total since reset.
    for (int j = 0; j < 4; j++) begin
      push_one(20 + j);
      wait_start();
      finish_job();
      step(); step();
    end
    chk("sat_hold", 32'(cnt2), 32'd3);
    chk("wide_count", 32'(cnt), 32'd5);

    // Randomized traffic with varying Done probability and rare resets.
    for (int blk = 0; blk < 30; blk++) begin
      int dprob;
      dprob = (blk % 5 == 4) ? 0 : int'($urandom_range(2, 10));
      for (int k = 0; k < 100; k++) begin
        set_in(($urandom_range(0, 399) == 0),
               ($urandom_range(0, 1) == 1),
               int'($urandom_range(0, 255)),
               (dprob != 0) && ($urandom_range(1, dprob) == 1),
               ($urandom_range(0, 15) == 0));
        step();
      end
    end
    set_in(0, 0, 0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
